// File: rtl/led_breathe_pkg.sv
// rtl/led_breathe_pkg.sv - shared ramp state encodings, reset constants and width helper for led_breathe
package led_breathe_pkg;

    typedef enum logic [1:0] {
        ST_UP      = 2'd0,
        ST_HOLD_HI = 2'd1,
        ST_DOWN    = 2'd2,
        ST_HOLD_LO = 2'd3
    } ramp_state_t;

    // Red starts dark and rising, green starts bright and falling.
    localparam ramp_state_t RED_RESET_STATE   = ST_UP;
    localparam bit          RED_RESET_FULL    = 1'b0;
    localparam ramp_state_t GREEN_RESET_STATE = ST_DOWN;
    localparam bit          GREEN_RESET_FULL  = 1'b1;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_ramp.sv
// rtl/led_ramp.sv - one breathing channel: ramp FSM, duty latch, PWM compare
// Optional LED_GAMMA_EN squares the level before it is latched as duty.
module led_ramp
    import led_breathe_pkg::*;
#(
    parameter int          PWM_BITS    = 8,
    parameter int          HOLD_STEPS  = 16,
    parameter ramp_state_t RESET_STATE = ST_UP,
    parameter bit          RESET_FULL  = 1'b0
) (
    input  logic                i_clock,
    input  logic                i_resetn,
    input  logic                i_enable,
    input  logic                i_step,
    input  logic                i_period_end,
    input  logic [PWM_BITS-1:0] i_pcnt,
    output logic                o_led
);

    localparam int                 HOLD_W    = cnt_width(HOLD_STEPS);
    localparam logic [PWM_BITS-1:0] LVL_MAX   = '1;
    localparam logic [PWM_BITS-1:0] LVL_ONE   = PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] LVL_RESET = RESET_FULL ? LVL_MAX : '0;
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);
    localparam logic [HOLD_W-1:0]   HOLD_ONE  = HOLD_W'(1);

    ramp_state_t         state_q, state_d;
    logic [PWM_BITS-1:0] level_q, level_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;

    always_ff @(posedge i_clock) begin
        if (!i_resetn) begin
            state_q <= RESET_STATE;
            level_q <= LVL_RESET;
            hold_q  <= '0;
            duty_q  <= LVL_RESET;
            o_led   <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            hold_q  <= hold_d;
            // duty takes the pre-step level so the waveform only changes at period edges
            if (i_period_end) begin
                duty_q <= duty_d;
            end
            o_led <= i_enable && (i_pcnt < duty_q);
        end
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        hold_d  = hold_q;
        if (i_step) begin
            case (state_q)
                ST_UP: begin
                    if (level_q != LVL_MAX) begin
                        level_d = level_q + LVL_ONE;
                    end
                    if (level_d == LVL_MAX) begin
                        state_d = ST_HOLD_HI;
                        hold_d  = '0;
                    end
                end
                ST_HOLD_HI: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = ST_DOWN;
                    end else begin
                        hold_d = hold_q + HOLD_ONE;
                    end
                end
                ST_DOWN: begin
                    if (level_q != '0) begin
                        level_d = level_q - LVL_ONE;
                    end
                    if (level_d == '0) begin
                        state_d = ST_HOLD_LO;
                        hold_d  = '0;
                    end
                end
                ST_HOLD_LO: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = ST_UP;
                    end else begin
                        hold_d = hold_q + HOLD_ONE;
                    end
                end
                default: state_d = RESET_STATE;
            endcase
        end
    end

`ifdef LED_GAMMA_EN
    logic [2*PWM_BITS-1:0] level_sq;
    always_comb begin
        level_sq = {{PWM_BITS{1'b0}}, level_q} * {{PWM_BITS{1'b0}}, level_q};
        duty_d   = PWM_BITS'(level_sq >> PWM_BITS);
    end
`else
    assign duty_d = level_q;
`endif

endmodule

// File: rtl/led_breathe.sv
// rtl/led_breathe.sv - two-channel antiphase PWM breathing LED driver (top)
// Build option LED_GAMMA_EN enables squared-level duty in each channel.
module led_breathe
    import led_breathe_pkg::*;
#(
    parameter int PWM_BITS     = 8,
    parameter int STEP_PERIODS = 4,
    parameter int HOLD_STEPS   = 16
) (
    input  logic i_clock,
    input  logic i_resetn,
    input  logic i_enable,
    output logic o_led_red,
    output logic o_led_green,
    output logic o_period_tick,
    output logic o_step_tick
);

    localparam int PRE_W = cnt_width(STEP_PERIODS);

    logic [PWM_BITS-1:0] pcnt;
    logic [PRE_W-1:0]    pre;
    logic                period_end;
    logic                step_evt;

    assign period_end = &pcnt;
    assign step_evt   = period_end && i_enable && (pre == PRE_W'(STEP_PERIODS - 1));

    always_ff @(posedge i_clock) begin
        if (!i_resetn) begin
            pcnt          <= '0;
            pre           <= '0;
            o_period_tick <= 1'b0;
            o_step_tick   <= 1'b0;
        end else begin
            pcnt          <= pcnt + PWM_BITS'(1);
            o_period_tick <= period_end;
            o_step_tick   <= step_evt;
            if (step_evt) begin
                pre <= '0;
            end else if (period_end && i_enable) begin
                pre <= pre + PRE_W'(1);
            end
        end
    end

    led_ramp #(
        .PWM_BITS    (PWM_BITS),
        .HOLD_STEPS  (HOLD_STEPS),
        .RESET_STATE (RED_RESET_STATE),
        .RESET_FULL  (RED_RESET_FULL)
    ) u_red (
        .i_clock      (i_clock),
        .i_resetn     (i_resetn),
        .i_enable     (i_enable),
        .i_step       (step_evt),
        .i_period_end (period_end),
        .i_pcnt       (pcnt),
        .o_led        (o_led_red)
    );

    led_ramp #(
        .PWM_BITS    (PWM_BITS),
        .HOLD_STEPS  (HOLD_STEPS),
        .RESET_STATE (GREEN_RESET_STATE),
        .RESET_FULL  (GREEN_RESET_FULL)
    ) u_green (
        .i_clock      (i_clock),
        .i_resetn     (i_resetn),
        .i_enable     (i_enable),
        .i_step       (step_evt),
        .i_period_end (period_end),
        .i_pcnt       (pcnt),
        .o_led        (o_led_green)
    );

endmodule

// File: tb/tb_led_breathe.sv
// tb/tb_led_breathe.sv - randomized bench for led_breathe against a position-based breathing model
module tb_led_breathe;

    localparam int PB   = 4;
    localparam int SP   = 1;
    localparam int HS   = 2;
    localparam int MAXL = (1 << PB) - 1;
    localparam int NPOS = 2 * MAXL + 2 * HS;

    logic i_clock  = 1'b0;
    logic i_resetn = 1'b0;
    logic i_enable = 1'b0;
    logic o_led_red, o_led_green, o_period_tick, o_step_tick;

    always #5 i_clock = ~i_clock;

    led_breathe #(
        .PWM_BITS     (PB),
        .STEP_PERIODS (SP),
        .HOLD_STEPS   (HS)
    ) dut (
        .i_clock       (i_clock),
        .i_resetn      (i_resetn),
        .i_enable      (i_enable),
        .o_led_red     (o_led_red),
        .o_led_green   (o_led_green),
        .o_period_tick (o_period_tick),
        .o_step_tick   (o_step_tick)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // model state: time within period, prescaler, and position within the breathing cycle
    int m_cnt, m_pre, m_pos, m_duty_r, m_duty_g;
    logic [3:0] m_outs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // red level after p steps; green is the same curve shifted half a cycle
    function automatic int red_lvl(input int p);
        if (p <= MAXL)               return p;
        else if (p <= MAXL + HS)     return MAXL;
        else if (p <= 2 * MAXL + HS) return MAXL - (p - MAXL - HS);
        else                         return 0;
    endfunction

    function automatic int duty_of(input int l);
`ifdef LED_GAMMA_EN
        return (l * l) >> PB;
`else
        return l;
`endif
    endfunction

    task automatic model_edge(input logic rn, input logic en);
        if (!rn) begin
            m_cnt    = 0;
            m_pre    = 0;
            m_pos    = 0;
            m_duty_r = 0;
            m_duty_g = MAXL;
            m_outs   = 4'b0000;
        end else begin
            m_outs[3] = en && (m_cnt < m_duty_r);
            m_outs[2] = en && (m_cnt < m_duty_g);
            m_outs[1] = (m_cnt == MAXL);
            m_outs[0] = (m_cnt == MAXL) && en && (m_pre == SP - 1);
            if (m_cnt == MAXL) begin
                m_duty_r = duty_of(red_lvl(m_pos));
                m_duty_g = duty_of(red_lvl((m_pos + MAXL + HS) % NPOS));
                if (en) begin
                    if (m_pre == SP - 1) begin
                        m_pre = 0;
                        m_pos = (m_pos + 1) % NPOS;
                    end else begin
                        m_pre++;
                    end
                end
            end
            m_cnt = (m_cnt + 1) % (MAXL + 1);
        end
    endtask

    task automatic cycle(input logic rn, input logic en);
        i_resetn = rn;
        i_enable = en;
        @(posedge i_clock);
        model_edge(rn, en);
        cyc++;
        #1;
        check("outs", {28'd0, o_led_red, o_led_green, o_period_tick, o_step_tick}, {28'd0, m_outs});
    endtask

    int hr, hg;
    int unsigned len;
    logic r_en, r_rn;

    initial begin
        repeat (3) cycle(1'b0, 1'b0);

        // full ramp from reset with per-period high-cycle counts
        for (int k = 0; k < 17; k++) begin
            hr = 0;
            hg = 0;
            for (int i = 0; i < 16; i++) begin
                cycle(1'b1, 1'b1);
                hr += int'(o_led_red);
                hg += int'(o_led_green);
                if (k == 0 && i == 15) check("first_period_tick", {31'd0, o_period_tick}, 32'd1);
            end
            if (k == 1) begin
                check("red_dark_p1", hr, 32'd0);
                check("green_full_p1", hg, duty_of(MAXL));
            end
            if (k == 16) begin
                check("red_full_p16", hr, duty_of(MAXL));
                check("green_dark_p16", hg, 32'd0);
            end
        end

        repeat (100) cycle(1'b1, 1'b0);
        repeat (200) cycle(1'b1, 1'b1);

        for (int s = 0; s < 80; s++) begin
            len  = $urandom_range(5, 60);
            r_en = ($urandom_range(0, 3) != 0);
            r_rn = ($urandom_range(0, 15) != 0);
            if (!r_rn) len = $urandom_range(1, 3);
            for (int i = 0; i < int'(len); i++) cycle(r_rn, r_en);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
